led_fade_ctrl: RTL
==================

# led_fade_ctrl

Brightness envelope generator that sits directly upstream of the `pwm` LED driver and produces its 8-bit `pwm_codeword`. On a `start` request it ramps the codeword from 0 up to a requested peak, holds for a programmed number of steps, then ramps back to 0 and pulses `done`. Whack-a-mole uses it to fade a mole LED in and out. One instance drives one `pwm` instance.

## Interface
- `STEP_DIV`, default 256: clock cycles per brightness step (tick). The default equals one 256-cycle PWM period. Legal range 2..65536.
- `STEP`, default 1: codeword increment/decrement per tick. Legal range 1..255.
- `clk` in 1: single clock; all state is clocked on the rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `start` in 1: request a fade cycle; sampled only in IDLE.
- `abort` in 1: cancel any fade in progress; codeword is forced to 0.
- `peak` in 8: target brightness; latched when `start` is accepted.
- `hold_len` in 8: hold duration minus 1, in ticks; latched when `start` is accepted.
- `pwm_codeword` out 8: brightness to the `pwm` stage; registered.
- `busy` out 1: high while state ≠ IDLE.
- `done` out 1: one-cycle pulse on normal completion.

## Operation
- The FSM has four states: IDLE, RISE, HOLD, FALL. Reset state is IDLE.
- Registers:
  - `peak_r`, `hold_r`: latched request.
  - `hold_cnt`: 8-bit hold counter.
  - `presc`: prescaler, width $clog2(STEP_DIV).
- Start acceptance: `start` is accepted in IDLE when `abort`=0.
  - Latch `peak_r`/`hold_r`, set `presc`←0, state←RISE.
  - `pwm_codeword` stays 0.
  - `start` is ignored in any other state; there is no queueing.
- Prescaler: in non-IDLE states, `presc` increments each cycle. When `presc`==STEP_DIV-1, the block raises a tick and `presc` wraps to 0. `presc` is held at 0 in IDLE.
- Tick actions compute the sum in 9 bits so it cannot overflow:
  - RISE: if `pwm_codeword`+STEP ≥ `peak_r`, then codeword←`peak_r`, `hold_cnt`←0, state←HOLD. Otherwise codeword←codeword+STEP.
  - HOLD: if `hold_cnt`==`hold_r`, state←FALL. Otherwise `hold_cnt`++.
  - FALL: if codeword ≤ STEP, then codeword←0, state←IDLE, `done`←1. Otherwise codeword←codeword−STEP.
- Abort: `abort`=1 in any non-IDLE state gives codeword←0, state←IDLE, `presc`←0, with no `done`.
  - Abort has priority over a tick in the same cycle.
  - In IDLE, `abort` has priority over `start`: the start is dropped.
- `peak`=0: the first RISE tick goes to HOLD with codeword 0, and FALL takes one tick. `done` still pulses.
- Non-multiple peaks (e.g. `peak`=5, STEP=2): RISE goes 2, 4, 5 (clamped to peak); FALL goes 3, 1, 0. The codeword never goes below 0 or above `peak_r`.
- `busy` is derived from the registered state and has no combinational path from inputs.

## Timing
- Reset values: `pwm_codeword`=0, `busy`=0, `done`=0, state IDLE, all counters 0.
- `reset` asserted mid-fade drops the codeword to 0 asynchronously; no `done` is produced.
- `start` sampled at edge E0 gives `busy`=1 after E0. The first codeword change happens at edge E0+STEP_DIV.
- Ticks then occur every STEP_DIV cycles.
- Let R = max(1, ceil(`peak`/STEP)).
  - Rise ticks: R. Hold ticks: `hold_len`+1. Fall ticks: R.
  - Busy duration: (2R + `hold_len` + 1)·STEP_DIV cycles.
- `done`:
  - High for exactly the one cycle after the final FALL tick edge.
  - That is the same cycle in which `busy`=0 and `pwm_codeword`=0.
  - A `start` present in that cycle is accepted, giving back-to-back fades with zero idle gap.
- Latched `peak_r`/`hold_r` make input changes during busy have no effect.

## Test plan
- Reset: assert `reset` asynchronously mid-RISE → outputs drop to 0 before the next edge. After release, the block stays in IDLE with `pwm_codeword`=0.
- Nominal fade (STEP_DIV=4, STEP=1, `peak`=4, `hold_len`=1, start at E0):
  - Codeword 1, 2, 3, 4 at E4/E8/E12/E16; holds 4 through E24.
  - Then 3, 2, 1, 0 at E28/E32/E36/E40.
  - `done` pulses after E40; `busy` is high for 40 cycles.
- Clamp and wrap (STEP=2, `peak`=5, `hold_len`=0) → sequence 2, 4, 5, 5, 3, 1, 0. Never exceeds 5; no underflow.
- Zero peak (`peak`=0, `hold_len`=0) → codeword stays 0, `busy` lasts 3·STEP_DIV cycles, `done` pulses once.
- Abort:
  - `abort` coincident with a RISE tick → codeword 0 next cycle, `busy`=0, no `done`.
  - `start` and `abort` together in IDLE → start is dropped.
- Back-to-back: hold `start` high continuously → a new fade is accepted in the `done` cycle. A `start` pulse while busy is ignored, and the latched `peak` is unaffected by input changes.

Source files
------------

// File: rtl/led_fade_ctrl.sv
// ---------------------------------------------------------------------------
// led_fade_ctrl
//
// Brightness envelope generator feeding the 8-bit codeword of a pwm LED
// driver. A start request ramps the codeword from 0 up to a latched peak,
// holds it for a latched number of brightness steps, ramps it back to 0 and
// then pulses done for one cycle. Abort (or reset) cancels a fade and forces
// the codeword to 0 without a done pulse.
//
// Parameters:
//   STEP_DIV  clock cycles per brightness step (tick), 2..65536
//   STEP      codeword increment/decrement per tick, 1..255
//
// Ports:
//   clk_i           single clock, rising edge
//   reset_i         asynchronous active-high reset
//   start_i         fade request, sampled only while idle
//   abort_i         cancel a fade in progress; wins over start while idle
//   peak_i          target brightness, latched on an accepted start
//   hold_len_i      hold duration minus 1 in ticks, latched on start
//   pwm_codeword_o  registered brightness to the pwm stage
//   busy_o          high while a fade is in progress
//   done_o          one-cycle pulse on normal completion
// ---------------------------------------------------------------------------
module led_fade_ctrl #(
    parameter int unsigned STEP_DIV = 256,
    parameter int unsigned STEP     = 1
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       start_i,
    input  logic       abort_i,
    input  logic [7:0] peak_i,
    input  logic [7:0] hold_len_i,
    output logic [7:0] pwm_codeword_o,
    output logic       busy_o,
    output logic       done_o
);

    localparam int unsigned PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(STEP_DIV - 1);
    localparam logic [8:0]    STEP9      = 9'(STEP);

    typedef enum logic [1:0] {
        IDLE,
        RISE,
        HOLD,
        FALL
    } state_t;

    state_t        state_q,    state_d;
    logic [7:0]    peak_q,     peak_d;
    logic [7:0]    hold_q,     hold_d;
    logic [7:0]    hold_cnt_q, hold_cnt_d;
    logic [PW-1:0] presc_q,    presc_d;
    logic [7:0]    code_q,     code_d;
    logic          done_q,     done_d;

    logic          tick;
    logic [8:0]    rise_sum;

    assign tick     = (presc_q == PRESC_LAST);
    // 9-bit sum so peak values near 255 cannot wrap past the clamp test
    assign rise_sum = {1'b0, code_q} + STEP9;

    always_comb begin
        state_d    = state_q;
        peak_d     = peak_q;
        hold_d     = hold_q;
        hold_cnt_d = hold_cnt_q;
        presc_d    = presc_q;
        code_d     = code_q;
        done_d     = 1'b0;

        if (state_q == IDLE) begin
            presc_d = '0;
            if (start_i && !abort_i) begin
                peak_d  = peak_i;
                hold_d  = hold_len_i;
                state_d = RISE;
            end
        end else if (abort_i) begin
            // abort outranks a tick landing in the same cycle
            code_d  = '0;
            presc_d = '0;
            state_d = IDLE;
        end else if (!tick) begin
            presc_d = presc_q + 1'b1;
        end else begin
            presc_d = '0;
            case (state_q)
                RISE: begin
                    if (rise_sum >= {1'b0, peak_q}) begin
                        code_d     = peak_q;
                        hold_cnt_d = '0;
                        state_d    = HOLD;
                    end else begin
                        code_d = rise_sum[7:0];
                    end
                end
                HOLD: begin
                    if (hold_cnt_q == hold_q) begin
                        state_d = FALL;
                    end else begin
                        hold_cnt_d = hold_cnt_q + 1'b1;
                    end
                end
                FALL: begin
                    if ({1'b0, code_q} <= STEP9) begin
                        code_d  = '0;
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        code_d = code_q - STEP9[7:0];
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            peak_q     <= '0;
            hold_q     <= '0;
            hold_cnt_q <= '0;
            presc_q    <= '0;
            code_q     <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            peak_q     <= peak_d;
            hold_q     <= hold_d;
            hold_cnt_q <= hold_cnt_d;
            presc_q    <= presc_d;
            code_q     <= code_d;
            done_q     <= done_d;
        end
    end

    assign pwm_codeword_o = code_q;
    assign busy_o         = (state_q != IDLE);
    assign done_o         = done_q;

endmodule
